reg_bus_master: RTL and testbench

Sequencer that drives the read/write strobe side of the processor's general-purpose register bank. Each register has a registered, zero-when-idle `out_bus`, a one-hot `Read` and `Write`, and a shared `in_bus`. The block accepts one command at a time (move, load-immediate, read-out) from the control unit and issues the strobe sequence the registers require. It also captures returned data and checks the bus for contention.

---
 rtl/reg_bus_pkg.sv | 17 +
 rtl/reg_sel_decode.sv | 15 +
 rtl/reg_bus_master.sv | 143 ++++++++++++++
 tb/tb_reg_bus_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: command encodings and sequencer states shared by the register-bus master.
package reg_bus_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        RESP
    } bus_state_t;

endpackage

// File: rtl/reg_sel_decode.sv
// reg_sel_decode: register index to one-hot strobe vector, gated by an enable.
module reg_sel_decode #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     onehot
);

    always_comb begin
        for (int i = 0; i < N; i++) onehot[i] = en && (sel == SEL_W'(i));
    end

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: sequences Read/Write strobes on the register bank for MOV, LDI and RD commands,
// captures returned data and flags index or bus-contention errors.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [SEL_W-1:0]          cmd_src,
    input  logic [SEL_W-1:0]          cmd_dst,
    input  logic [WIDTH-1:0]          cmd_imm,
    output logic                      rsp_valid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      err,
    output logic [NUM_REGS-1:0]       reg_read,
    output logic [NUM_REGS-1:0]       reg_write,
    output logic [WIDTH-1:0]          reg_in_bus,
    input  logic [NUM_REGS*WIDTH-1:0] reg_out_bus
);

    bus_state_t          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [SEL_W-1:0]    src_q, src_d, dst_q, dst_d, wr_sel;
    logic [WIDTH-1:0]    data_q, data_d, in_bus_q, in_bus_d, rsp_data_q, rsp_data_d, or_val;
    logic [NUM_REGS-1:0] read_q, read_d, write_q, write_d;
    logic                rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic                rd_en, wr_en, src_oor, dst_oor, bad, contention;

    assign src_oor = 32'(cmd_src) >= NUM_REGS;
    assign dst_oor = 32'(cmd_dst) >= NUM_REGS;

    // Idle registers drive zero, so the OR of all slices is the selected value unless another drives.
    always_comb begin
        or_val     = '0;
        contention = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            or_val = or_val | reg_out_bus[i*WIDTH +: WIDTH];
            if (src_q != SEL_W'(i) && |reg_out_bus[i*WIDTH +: WIDTH]) contention = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        data_d      = data_q;
        in_bus_d    = in_bus_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        wr_sel      = dst_q;
        bad         = ((cmd_op == OP_MOV || cmd_op == OP_RD) && src_oor) ||
                      ((cmd_op == OP_MOV || cmd_op == OP_LDI) && dst_oor);
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d  = cmd_op;
                src_d = cmd_src;
                dst_d = cmd_dst;
                if (bad) begin
                    err_d = 1'b1;
                end else if (cmd_op == OP_LDI) begin
                    state_d  = WRITE;
                    wr_en    = 1'b1;
                    wr_sel   = cmd_dst;
                    data_d   = cmd_imm;
                    in_bus_d = cmd_imm;
                end else if (cmd_op != OP_NOP) begin
                    state_d = READ;
                    rd_en   = 1'b1;
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                data_d = or_val;
                err_d  = contention;
                if (op_q == OP_MOV) begin
                    state_d  = WRITE;
                    wr_en    = 1'b1;
                    in_bus_d = or_val;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = or_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    reg_sel_decode #(.N(NUM_REGS), .SEL_W(SEL_W)) u_rd_dec (
        .en(rd_en), .sel(cmd_src), .onehot(read_d)
    );

    reg_sel_decode #(.N(NUM_REGS), .SEL_W(SEL_W)) u_wr_dec (
        .en(wr_en), .sel(wr_sel), .onehot(write_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            in_bus_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            read_q      <= '0;
            write_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            in_bus_q    <= in_bus_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            read_q      <= read_d;
            write_q     <= write_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign err        = err_q;
    assign reg_read   = read_q;
    assign reg_write  = write_q;
    assign reg_in_bus = in_bus_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed bench with a behavioural register bank and an RD result scoreboard.
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_valid6 = 1'b0;
    logic [1:0]  cmd_op = 2'b11;
    logic [2:0]  cmd_src = '0, cmd_dst = '0;
    logic [15:0] cmd_imm = '0;
    logic        cmd_ready, rsp_valid, err;
    logic [15:0] rsp_data, reg_in_bus;
    logic [7:0]  reg_read, reg_write;
    logic [127:0] reg_out_bus;
    logic        ready6, rsp_valid6, err6;
    logic [15:0] rsp_data6, in_bus6;
    logic [5:0]  read6, write6;

    logic [15:0] bank [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                              16'h1004, 16'h1005, 16'h1006, 16'h1007};
    logic [15:0] out_q [8] = '{default: 16'h0};
    logic        inject = 1'b0;
    logic [15:0] exp_q [$];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    reg_bus_master #(.NUM_REGS(8), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
        .reg_read(reg_read), .reg_write(reg_write), .reg_in_bus(reg_in_bus),
        .reg_out_bus(reg_out_bus)
    );

    reg_bus_master #(.NUM_REGS(6), .WIDTH(16)) dut6 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid6), .cmd_ready(ready6),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid6), .rsp_data(rsp_data6), .err(err6),
        .reg_read(read6), .reg_write(write6), .reg_in_bus(in_bus6),
        .reg_out_bus(96'h0)
    );

    // Register bank: registered out_bus that is zero unless Read was high.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reg_write[i]) bank[i] <= reg_in_bus;
            out_q[i] <= reg_read[i] ? bank[i] : 16'h0;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++)
            reg_out_bus[i*16 +: 16] = out_q[i] | ((i == 2 && inject) ? 16'h0001 : 16'h0000);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic wait_rsp(input string tag, input int lat);
        int  cyc;
        bit  seen;
        logic [15:0] want;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 10) begin
            tick();
            cyc++;
            if (rsp_valid) seen = 1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'(seen), 32'd1);
        end else begin
            want = exp_q.pop_front();
            chk({tag, "_data"}, 32'(rsp_data), 32'(want));
            chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        end
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_read", 32'(reg_read), 32'h0);
        chk("rst_write", 32'(reg_write), 32'h0);
        chk("rst_in_bus", 32'(reg_in_bus), 32'h0);
        chk("rst_rsp", {15'd0, rsp_valid, rsp_data}, 32'h0);
        chk("rst_err", 32'(err), 32'd0);

        // LDI dst=3 imm=BEEF
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dst = 3'd3; cmd_imm = 16'hBEEF;
        tick();
        cmd_valid = 1'b0; cmd_imm = 16'h0;
        chk("ldi_write", 32'(reg_write), 32'h08);
        chk("ldi_in_bus", 32'(reg_in_bus), 32'hBEEF);
        chk("ldi_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        chk("ldi_write_off", 32'(reg_write), 32'h0);
        chk("ldi_reg3", 32'(bank[3]), 32'hBEEF);
        chk("ldi_ready", 32'(cmd_ready), 32'd1);

        // MOV src=3 dst=5
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src = 3'd3; cmd_dst = 3'd5;
        tick();
        cmd_valid = 1'b0; cmd_src = 3'd0; cmd_dst = 3'd0;
        chk("mov_read", 32'(reg_read), 32'h08);
        chk("mov_write_e0", 32'(reg_write), 32'h0);
        tick();
        chk("mov_read_off", 32'(reg_read), 32'h0);
        tick();
        chk("mov_write", 32'(reg_write), 32'h20);
        chk("mov_in_bus", 32'(reg_in_bus), 32'hBEEF);
        chk("mov_err", 32'(err), 32'd0);
        tick();
        chk("mov_reg5", 32'(bank[5]), 32'hBEEF);
        chk("mov_ready", 32'(cmd_ready), 32'd1);

        // RD src=7
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_src = 3'd7;
        exp_q.push_back(16'h1007);
        tick();
        cmd_valid = 1'b0;
        chk("rd_read", 32'(reg_read), 32'h80);
        wait_rsp("rd7", 2);
        chk("rd7_err", 32'(err), 32'd0);
        tick();
        chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rd_hold", 32'(rsp_data), 32'h1007);

        // NOP x3
        cmd_valid = 1'b1; cmd_op = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nop_ready", 32'(cmd_ready), 32'd1);
            chk("nop_strobes", {reg_read, reg_write}, 32'h0);
        end
        cmd_valid = 1'b0;

        // Out-of-range source on the 6-register instance
        cmd_valid6 = 1'b1; cmd_op = 2'b00; cmd_src = 3'd7; cmd_dst = 3'd1;
        tick();
        cmd_valid6 = 1'b0;
        chk("oor_err", 32'(err6), 32'd1);
        chk("oor_strobes", {read6, write6}, 32'h0);
        chk("oor_ready", 32'(ready6), 32'd1);
        tick();
        chk("oor_err_pulse", 32'(err6), 32'd0);
        chk("oor_write", 32'(write6), 32'h0);

        // RD src=4 with slice 2 driving during CAPT
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_src = 3'd4;
        exp_q.push_back(16'h1005);
        tick();
        cmd_valid = 1'b0;
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
        if (rsp_valid) chk("cont_rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
        chk("cont_err", 32'(err), 32'd1);
        tick();
        chk("cont_err_pulse", 32'(err), 32'd0);

        // Reset between E1 and E2 of MOV src=7 dst=0
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src = 3'd7; cmd_dst = 3'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_strobes", {reg_read, reg_write}, 32'h0);
        tick();
        chk("arst_write_e2", 32'(reg_write), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_reg0", 32'(bank[0]), 32'h1000);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        chk("arst_write", 32'(reg_write), 32'h0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
